// File: rtl/glay_cache_req_arbiter_n_pkg.sv
// -----------------------------------------------------------------------------
// glay_cache_req_arbiter_n_pkg
// Shared types for the cache request arbiter: arbiter FSM state encoding,
// default requester count, the cache frontend request/response structs and a
// small round-robin pointer helper.
// -----------------------------------------------------------------------------
package glay_cache_req_arbiter_n_pkg;

    // Default number of requesters sharing one cache frontend port.
    localparam int GLAY_NUM_REQ = 4;

    localparam int CACHE_ADDR_W = 32;
    localparam int CACHE_DATA_W = 32;
    localparam int CACHE_STRB_W = CACHE_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_RESET = 2'd0,
        ARB_IDLE  = 2'd1,
        ARB_BUSY  = 2'd2,
        ARB_DONE  = 2'd3
    } cache_arbiter_state;

    // Control side-band towards the iob-cache frontend.
    typedef struct packed {
        logic force_inv_in;
        logic wtb_empty_in;
    } GlayCacheCtrlIo;

    typedef struct packed {
        logic                    valid;
        logic [CACHE_ADDR_W-1:0] addr;
        logic [CACHE_DATA_W-1:0] wdata;
        logic [CACHE_STRB_W-1:0] wstrb;
        GlayCacheCtrlIo          ctrl;
    } GlayCacheRequestPayloadInput;

    typedef struct packed {
        logic                        valid;
        GlayCacheRequestPayloadInput payload;
    } GlayCacheRequestInterfaceInput;

    typedef struct packed {
        logic [CACHE_DATA_W-1:0] rdata;
        logic                    ready;
    } GlayCacheRequestPayloadOutput;

    typedef struct packed {
        logic                         valid;
        GlayCacheRequestPayloadOutput payload;
    } GlayCacheRequestInterfaceOutput;

    // Next round-robin position after index cur, wrapping explicitly at n-1.
    function automatic int rr_next(input int cur, input int n);
        if (cur >= n - 1) begin
            return 0;
        end else begin
            return cur + 1;
        end
    endfunction

endpackage

// File: rtl/glay_cache_req_arbiter_n_rr_select.sv
// -----------------------------------------------------------------------------
// glay_rr_priority_select
// Combinational round-robin priority picker. Searches the request vector
// upward from rr_ptr, wrapping modulo NUM_REQ, and reports the first set index.
// Ports:
//   req_vec  in   NUM_REQ   one bit per requester
//   rr_ptr   in   REQ_ID_W  index that has highest priority this round
//   found    out  1         at least one request present
//   winner   out  REQ_ID_W  selected index (0 when found is low)
// -----------------------------------------------------------------------------
module glay_rr_priority_select #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_vec,
    input  logic [REQ_ID_W-1:0] rr_ptr,
    output logic                found,
    output logic [REQ_ID_W-1:0] winner
);

    // Rotated first-set search; the first hit in search order latches the winner.
    always_comb begin
        logic [REQ_ID_W-1:0] idx_v;
        logic                hit_v;
        found  = 1'b0;
        winner = '0;
        idx_v  = '0;
        hit_v  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v  = REQ_ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            hit_v  = !found && req_vec[idx_v];
            found  = found | hit_v;
            winner = hit_v ? idx_v : winner;
        end
    end

endmodule

// File: rtl/glay_cache_req_arbiter_n.sv
// -----------------------------------------------------------------------------
// glay_cache_req_arbiter_n
// Round-robin arbiter sharing one blocking cache frontend port among NUM_REQ
// requesters, one transaction in flight at a time. Responses are routed back
// to the requester that was granted.
// Ports:
//   ap_clk         in   clock, rising edge
//   areset         in   synchronous active-high reset
//   req_in         in   NUM_REQ requests (held until response)
//   req_out        out  NUM_REQ responses, valid is a one-cycle pulse
//   cache_req_out  out  request towards the cache frontend
//   cache_resp_in  in   response from the cache, payload.ready = completion
//   grant_id       out  current or most recent grant index
//   arbiter_busy   out  high while a transaction is in BUSY or DONE
// -----------------------------------------------------------------------------
module glay_cache_req_arbiter_n
    import glay_cache_req_arbiter_n_pkg::*;
#(
    parameter int NUM_REQ  = GLAY_NUM_REQ,
    parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
    input  logic                                         ap_clk,
    input  logic                                         areset,
    input  GlayCacheRequestInterfaceInput  [NUM_REQ-1:0] req_in,
    output GlayCacheRequestInterfaceOutput [NUM_REQ-1:0] req_out,
    output GlayCacheRequestInterfaceInput                cache_req_out,
    input  GlayCacheRequestInterfaceOutput               cache_resp_in,
    output logic [REQ_ID_W-1:0]                          grant_id,
    output logic                                         arbiter_busy
);

    cache_arbiter_state                           state_r;
    logic [REQ_ID_W-1:0]                          rr_ptr_r;
    logic [REQ_ID_W-1:0]                          grant_id_r;
    logic                                         cache_valid_r;
    logic                                         busy_r;
    GlayCacheRequestPayloadInput                  cache_payload_r;
    GlayCacheRequestInterfaceOutput [NUM_REQ-1:0] req_out_r;

    logic [NUM_REQ-1:0]  req_vec_s;
    logic                found_s;
    logic [REQ_ID_W-1:0] winner_s;

    // Collect the per-requester valid bits for the priority picker.
    always_comb begin
        req_vec_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec_s[i] = req_in[i].valid;
        end
    end

    glay_rr_priority_select #(
        .NUM_REQ  (NUM_REQ),
        .REQ_ID_W (REQ_ID_W)
    ) u_rr_select (
        .req_vec (req_vec_s),
        .rr_ptr  (rr_ptr_r),
        .found   (found_s),
        .winner  (winner_s)
    );

    // Arbiter FSM with the pointer, grant and payload registers.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_r         <= ARB_RESET;
            rr_ptr_r        <= '0;
            grant_id_r      <= '0;
            cache_valid_r   <= 1'b0;
            busy_r          <= 1'b0;
            cache_payload_r <= '0;
            req_out_r       <= '0;
        end else begin
            case (state_r)
                ARB_RESET: begin
                    state_r <= ARB_IDLE;
                end
                ARB_IDLE: begin
                    if (found_s) begin
                        grant_id_r      <= winner_s;
                        cache_payload_r <= req_in[winner_s].payload;
                        cache_valid_r   <= 1'b1;
                        busy_r          <= 1'b1;
                        state_r         <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // Ready is only honoured here; strays in other states are ignored.
                    if (cache_resp_in.payload.ready) begin
                        cache_valid_r <= 1'b0;
                        rr_ptr_r      <= REQ_ID_W'(rr_next(int'(grant_id_r), NUM_REQ));
                        for (int j = 0; j < NUM_REQ; j++) begin
                            if (REQ_ID_W'(j) == grant_id_r) begin
                                req_out_r[j].valid   <= 1'b1;
                                req_out_r[j].payload <= cache_resp_in.payload;
                            end else begin
                                req_out_r[j] <= '0;
                            end
                        end
                        state_r <= ARB_DONE;
                    end
                end
                ARB_DONE: begin
                    req_out_r <= '0;
                    busy_r    <= 1'b0;
                    state_r   <= ARB_IDLE;
                end
                default: begin
                    cache_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                    req_out_r     <= '0;
                    state_r       <= ARB_RESET;
                end
            endcase
        end
    end

    // Outgoing cache request: registered payload, fixed control side-band.
    always_comb begin
        cache_req_out                           = '0;
        cache_req_out.valid                     = cache_valid_r;
        cache_req_out.payload                   = cache_payload_r;
        cache_req_out.payload.valid             = cache_valid_r;
        cache_req_out.payload.ctrl.force_inv_in = 1'b0;
        cache_req_out.payload.ctrl.wtb_empty_in = 1'b1;
    end

    assign req_out      = req_out_r;
    assign grant_id     = grant_id_r;
    assign arbiter_busy = busy_r;

endmodule
